// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS-subset pipeline: register file,
// control decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] if_id_instruction,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] id_ex_pc_plus4,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [3:0]  id_ex_alu_op,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_alu_src,
    output logic        id_ex_branch,
    output logic        id_ex_jump,
    output logic [31:0] id_ex_jump_target
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] jump_target;

    assign opcode      = if_id_instruction[31:26];
    assign rs          = if_id_instruction[25:21];
    assign rt          = if_id_instruction[20:16];
    assign rd          = if_id_instruction[15:11];
    assign funct       = if_id_instruction[5:0];
    assign imm         = {{16{if_id_instruction[15]}}, if_id_instruction[15:0]};
    assign jump_target = {if_id_pc[31:28], if_id_instruction[25:0], 2'b00};

    logic [31:0] regs [32];
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_active;

    assign wb_active = wb_reg_write && (wb_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_active) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-through bypass lets a value retiring in WB be consumed in the same cycle.
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (rs == 5'd0)                      rs_data = '0;
        else if (wb_active && wb_rd == rs)   rs_data = wb_data;
        if (rt == 5'd0)                      rt_data = '0;
        else if (wb_active && wb_rd == rt)   rt_data = wb_data;
    end

    logic [3:0] alu_op;
    logic [4:0] dest;
    logic       reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump;
    logic       uses_rt;

    always_comb begin
        alu_op     = ALU_ADD;
        dest       = 5'd0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        uses_rt    = 1'b0;
        case (opcode)
            6'h00: begin
                uses_rt = 1'b1;
                case (funct)
                    6'h20: begin alu_op = ALU_ADD; reg_write = 1'b1; dest = rd; end
                    6'h22: begin alu_op = ALU_SUB; reg_write = 1'b1; dest = rd; end
                    6'h24: begin alu_op = ALU_AND; reg_write = 1'b1; dest = rd; end
                    6'h25: begin alu_op = ALU_OR;  reg_write = 1'b1; dest = rd; end
                    6'h2A: begin alu_op = ALU_SLT; reg_write = 1'b1; dest = rd; end
                    default: ;
                endcase
            end
            6'h08: begin alu_src = 1'b1; reg_write = 1'b1; dest = rt; end
            6'h23: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                dest       = rt;
            end
            6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; uses_rt = 1'b1; end
            6'h04: begin alu_op = ALU_SUB; branch = 1'b1; uses_rt = 1'b1; end
            6'h02: jump = 1'b1;
            default: ;
        endcase
    end

    logic hz;
    assign hz    = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == rs) || ((id_ex_rt == rt) && uses_rt));
    assign stall = hz && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || hz) begin
            // Reset and bubbles share one clear; only reset restores the PC seed.
            id_ex_pc_plus4    <= rst ? RESET_PC_PLUS4 : 32'd0;
            id_ex_rs_data     <= '0;
            id_ex_rt_data     <= '0;
            id_ex_imm         <= '0;
            id_ex_rs          <= '0;
            id_ex_rt          <= '0;
            id_ex_rd          <= '0;
            id_ex_alu_op      <= ALU_ADD;
            id_ex_reg_write   <= 1'b0;
            id_ex_mem_read    <= 1'b0;
            id_ex_mem_write   <= 1'b0;
            id_ex_mem_to_reg  <= 1'b0;
            id_ex_alu_src     <= 1'b0;
            id_ex_branch      <= 1'b0;
            id_ex_jump        <= 1'b0;
            id_ex_jump_target <= '0;
        end else begin
            id_ex_pc_plus4    <= if_id_pc;
            id_ex_rs_data     <= rs_data;
            id_ex_rt_data     <= rt_data;
            id_ex_imm         <= imm;
            id_ex_rs          <= rs;
            id_ex_rt          <= rt;
            id_ex_rd          <= dest;
            id_ex_alu_op      <= alu_op;
            id_ex_reg_write   <= reg_write;
            id_ex_mem_read    <= mem_read;
            id_ex_mem_write   <= mem_write;
            id_ex_mem_to_reg  <= mem_to_reg;
            id_ex_alu_src     <= alu_src;
            id_ex_branch      <= branch;
            id_ex_jump        <= jump;
            id_ex_jump_target <= jump_target;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, bypass, load-use stall,
// flush priority, reset behaviour and r0 handling.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_jump_target;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic        id_ex_alu_src, id_ex_branch, id_ex_jump;

    int n_checks = 0;
    int n_errors = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall),
        .id_ex_pc_plus4(id_ex_pc_plus4), .id_ex_rs_data(id_ex_rs_data),
        .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
        .id_ex_jump_target(id_ex_jump_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
        if_id_pc          = pc;
        if_id_instruction = instr;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        issue(32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_pc_plus4", id_ex_pc_plus4, 32'h4);
        chk("rst_reg_write", {31'd0, id_ex_reg_write}, 32'd0);
        chk("rst_mem_read", {31'd0, id_ex_mem_read}, 32'd0);
        chk("rst_jump", {31'd0, id_ex_jump}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("nop_reg_write", {31'd0, id_ex_reg_write}, 32'd0);
        chk("nop_rd", {27'd0, id_ex_rd}, 32'd0);

        // add r3,r5,r6 with r5 retiring from WB in the same cycle
        issue(32'h104, 32'h00A61820);
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        wb_reg_write = 1'b0;
        chk("byp_rs_data", id_ex_rs_data, 32'h1234);
        chk("byp_rt_data", id_ex_rt_data, 32'h0);
        chk("byp_alu_op", {28'd0, id_ex_alu_op}, 32'd0);
        chk("byp_rd", {27'd0, id_ex_rd}, 32'd3);
        chk("byp_reg_write", {31'd0, id_ex_reg_write}, 32'd1);
        chk("byp_pc_plus4", id_ex_pc_plus4, 32'h104);
        tick();
        chk("rf_r5_stored", id_ex_rs_data, 32'h1234);

        // lw r2,4(r1) followed by dependent add r4,r2,r2
        issue(32'h108, 32'h8C220004);
        #1;
        chk("lw_no_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("lw_mem_read", {31'd0, id_ex_mem_read}, 32'd1);
        chk("lw_mem_to_reg", {31'd0, id_ex_mem_to_reg}, 32'd1);
        chk("lw_alu_src", {31'd0, id_ex_alu_src}, 32'd1);
        chk("lw_rd", {27'd0, id_ex_rd}, 32'd2);
        chk("lw_imm", id_ex_imm, 32'h4);
        issue(32'h10C, 32'h00422020);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_rw", {31'd0, id_ex_reg_write}, 32'd0);
        chk("lu_bubble_mr", {31'd0, id_ex_mem_read}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_add_rs", {27'd0, id_ex_rs}, 32'd2);
        chk("lu_add_rt", {27'd0, id_ex_rt}, 32'd2);
        chk("lu_add_rd", {27'd0, id_ex_rd}, 32'd4);
        chk("lu_add_rw", {31'd0, id_ex_reg_write}, 32'd1);

        // lw r2 again: addi writing r2 does not read rt, flush overrides hazard
        issue(32'h110, 32'h8C220004);
        tick();
        issue(32'h114, 32'h20620001);
        #1;
        chk("addi_rt_no_stall", {31'd0, stall}, 32'd0);
        issue(32'h114, 32'h00422020);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_bubble_rw", {31'd0, id_ex_reg_write}, 32'd0);
        chk("flush_bubble_mr", {31'd0, id_ex_mem_read}, 32'd0);
        chk("flush_bubble_pc", id_ex_pc_plus4, 32'h0);

        // addi r7,r0,-1
        issue(32'h118, 32'h2007FFFF);
        tick();
        chk("addi_imm", id_ex_imm, 32'hFFFFFFFF);
        chk("addi_alu_src", {31'd0, id_ex_alu_src}, 32'd1);
        chk("addi_rd", {27'd0, id_ex_rd}, 32'd7);
        chk("addi_rw", {31'd0, id_ex_reg_write}, 32'd1);

        // j 0x100 from the 0x1000_0000 region
        issue(32'h10000008, 32'h08000040);
        tick();
        chk("j_jump", {31'd0, id_ex_jump}, 32'd1);
        chk("j_target", id_ex_jump_target, 32'h10000100);
        chk("j_rw", {31'd0, id_ex_reg_write}, 32'd0);

        // beq r5,r6 / sw r2,8(r1) / slt / or
        issue(32'h200, 32'h10A60003);
        tick();
        chk("beq_alu_op", {28'd0, id_ex_alu_op}, 32'd1);
        chk("beq_branch", {31'd0, id_ex_branch}, 32'd1);
        issue(32'h204, 32'hAC220008);
        tick();
        chk("sw_mem_write", {31'd0, id_ex_mem_write}, 32'd1);
        chk("sw_rw", {31'd0, id_ex_reg_write}, 32'd0);
        chk("sw_imm", id_ex_imm, 32'h8);
        issue(32'h208, 32'h00A6182A);
        tick();
        chk("slt_alu_op", {28'd0, id_ex_alu_op}, 32'd4);
        issue(32'h20C, 32'h00A61825);
        tick();
        chk("or_alu_op", {28'd0, id_ex_alu_op}, 32'd3);
        issue(32'h210, 32'h00A61824);
        tick();
        chk("and_alu_op", {28'd0, id_ex_alu_op}, 32'd2);
        issue(32'h214, 32'h00A61822);
        tick();
        chk("sub_alu_op", {28'd0, id_ex_alu_op}, 32'd1);

        // Write-back to r0 is ignored, both bypassed and stored
        issue(32'h300, 32'h00001820);
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        wb_reg_write = 1'b0;
        chk("r0_bypass", id_ex_rs_data, 32'h0);
        tick();
        chk("r0_stored", id_ex_rs_data, 32'h0);

        // Unknown opcode 0x3F decodes to all-zero controls
        issue(32'h304, 32'hFC000000);
        tick();
        chk("unk_rw", {31'd0, id_ex_reg_write}, 32'd0);
        chk("unk_ctrl", {25'd0, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
                         id_ex_alu_src, id_ex_branch, id_ex_jump, 1'b0}, 32'd0);
        chk("unk_alu_op", {28'd0, id_ex_alu_op}, 32'd0);

        // Mid-stream reset clears ID/EX at once and the register file
        issue(32'h400, 32'h00A61820);
        tick();
        chk("pre_rst_rs_data", id_ex_rs_data, 32'h1234);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", id_ex_pc_plus4, 32'h4);
        chk("mid_rst_rw", {31'd0, id_ex_reg_write}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_r5", id_ex_rs_data, 32'h0);
        chk("post_rst_rw", {31'd0, id_ex_reg_write}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
